// File: rtl/if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_fetch                                                      |
// | Purpose  : Instruction-fetch stage. Owns the PC, issues instruction-bus  |
// |            requests and presents {pc, inst} to the IF/ID register.       |
// |            Slow bus acks raise stallreq_o. Branch redirects from ID are  |
// |            queued when they cannot be taken at once, so the delay slot   |
// |            is always delivered before the target. Exception flushes      |
// |            from ctrl override everything else.                           |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            stall[5:0]         ctrl stall vector (bit0 = PC hold)         |
// |            flush_i/new_pc_i   exception redirect                         |
// |            branch_flag_i/branch_target_address_i  branch redirect        |
// |            ibus_req_o/ibus_addr_o/ibus_ack_i/ibus_rdata_i  inst bus      |
// |            pc_o/inst_o        to IF/ID                                   |
// |            stallreq_o         stall request to ctrl                      |
// |            addr_err_o         misaligned fetch flag                      |
// | Macro    : IF_MISALIGN_CHK_EN enables misaligned-fetch detection.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  output logic        addr_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] hold_pc, hold_pc_nx;
  logic [31:0] hold_inst, hold_inst_nx;
  logic        pend_valid, pend_valid_nx;
  logic [31:0] pend_target, pend_target_nx;
  // Address of the transaction still in flight when a flush hit it; the
  // bus must see that request held until its ack arrives.
  logic [31:0] drain_addr, drain_addr_nx;

  logic [31:0] next_pc;
  logic [31:0] fetch_addr;
  logic        misalign;
  logic        ack_eff;

  // Only the PC-hold bit is needed here: ctrl never stalls IF without PC.
  logic        unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef IF_MISALIGN_CHK_EN
  logic hold_err, hold_err_nx;
  assign misalign   = (state == S_FETCH) && (fetch_pc[1:0] != 2'b00);
  assign fetch_addr = fetch_pc;
`else
  assign misalign   = 1'b0;
  assign fetch_addr = {fetch_pc[31:2], 2'b00};
`endif

  // A misaligned fetch never reaches the bus and completes in one cycle.
  assign ack_eff = ibus_ack_i | misalign;

  assign next_pc = pend_valid    ? pend_target :
                   branch_flag_i ? branch_target_address_i :
                                   fetch_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      hold_pc     <= 32'h0;
      hold_inst   <= 32'h0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      drain_addr  <= 32'h0;
`ifdef IF_MISALIGN_CHK_EN
      hold_err    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      hold_pc     <= hold_pc_nx;
      hold_inst   <= hold_inst_nx;
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
      drain_addr  <= drain_addr_nx;
`ifdef IF_MISALIGN_CHK_EN
      hold_err    <= hold_err_nx;
`endif
    end
  end

  always_comb begin
    state_nx       = state;
    fetch_pc_nx    = fetch_pc;
    hold_pc_nx     = hold_pc;
    hold_inst_nx   = hold_inst;
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
    drain_addr_nx  = drain_addr;
`ifdef IF_MISALIGN_CHK_EN
    hold_err_nx    = hold_err;
`endif
    ibus_req_o     = 1'b0;
    ibus_addr_o    = 32'h0;
    pc_o           = 32'h0;
    inst_o         = 32'h0;
    stallreq_o     = 1'b0;
    addr_err_o     = 1'b0;

    case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
        if (flush_i) begin
          fetch_pc_nx   = new_pc_i;
          pend_valid_nx = 1'b0;
        end
      end

      S_FETCH: begin
        ibus_req_o  = ~misalign;
        ibus_addr_o = fetch_addr;
        pc_o        = fetch_pc;
        inst_o      = (ibus_ack_i && !misalign) ? ibus_rdata_i : 32'h0;
        stallreq_o  = ~ack_eff;
        addr_err_o  = misalign;
        if (flush_i) begin
          pend_valid_nx = 1'b0;
          fetch_pc_nx   = new_pc_i;
          if (!ack_eff) begin
            drain_addr_nx = fetch_addr;
            state_nx      = S_DRAIN;
          end
        end else if (ack_eff && !stall[0]) begin
          fetch_pc_nx   = next_pc;
          pend_valid_nx = 1'b0;
        end else begin
          if (ack_eff) begin
            hold_pc_nx   = fetch_pc;
            hold_inst_nx = inst_o;
`ifdef IF_MISALIGN_CHK_EN
            hold_err_nx  = misalign;
`endif
            state_nx     = S_HOLD;
          end
          // No advance this cycle: remember the branch for later.
          if (branch_flag_i) begin
            pend_valid_nx  = 1'b1;
            pend_target_nx = branch_target_address_i;
          end
        end
      end

      S_HOLD: begin
        pc_o   = hold_pc;
        inst_o = hold_inst;
`ifdef IF_MISALIGN_CHK_EN
        addr_err_o = hold_err;
`endif
        if (flush_i) begin
          pend_valid_nx = 1'b0;
          fetch_pc_nx   = new_pc_i;
          state_nx      = S_FETCH;
        end else if (!stall[0]) begin
          fetch_pc_nx   = next_pc;
          pend_valid_nx = 1'b0;
          state_nx      = S_FETCH;
        end else if (branch_flag_i) begin
          pend_valid_nx  = 1'b1;
          pend_target_nx = branch_target_address_i;
        end
      end

      S_DRAIN: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = drain_addr;
        stallreq_o  = 1'b1;
        if (flush_i) begin
          fetch_pc_nx   = new_pc_i;
          pend_valid_nx = 1'b0;
        end
        if (ibus_ack_i) begin
          state_nx = S_FETCH;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_if_fetch                                                   |
// | Purpose  : Self-checking bench for if_fetch. Delivered {pc, inst} pairs  |
// |            are checked against a scoreboard of expected deliveries;     |
// |            each scenario task also checks bus/stall outputs inline.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        addr_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } deliv_t;

  deliv_t exp_q[$];

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus_req_o              (ibus_req_o),
    .ibus_addr_o             (ibus_addr_o),
    .ibus_ack_i              (ibus_ack_i),
    .ibus_rdata_i            (ibus_rdata_i),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .stallreq_o              (stallreq_o),
    .addr_err_o              (addr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h20) ? 32'h2402_0005 : (32'h8C00_0000 ^ a);
  endfunction

  assign ibus_rdata_i = mem(ibus_addr_o);

  // Scoreboard: a delivery is a FETCH-with-ack cycle (request, ack, no stall).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ibus_req_o && ibus_ack_i && !stallreq_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL deliv_unexpected pc=%h inst=%h required=none", pc_o, inst_o);
        end else begin
          deliv_t e;
          e = exp_q.pop_front();
          if (pc_o !== e.pc || inst_o !== e.inst) begin
            bad++;
            $display("FAIL deliv pc=%h inst=%h required pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic a, input logic [5:0] s, input logic b,
                      input logic [31:0] t, input logic f, input logic [31:0] n);
    @(negedge clk);
    ibus_ack_i = a; stall = s; branch_flag_i = b;
    branch_target_address_i = t; flush_i = f; new_pc_i = n;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ibus_ack_i = 1'b0; stall = 6'd0; branch_flag_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    deliv_t e;
    e.pc = pc; e.inst = inst;
    exp_q.push_back(e);
  endtask

  // n zero-wait fetches from address 0 after reset.
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      push(32'(4 * i), mem(32'(4 * i)));
      step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (ibus_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b required=0", ibus_req_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h required=0", pc_o); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h required=0", inst_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq got=%b required=0", stallreq_o); end
    total++; if (addr_err_o !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b required=0", addr_err_o); end
    rst = 1'b0;
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      bad++; $display("FAIL first_req got req=%b addr=%h required req=1 addr=0", ibus_req_o, ibus_addr_o); end
    total++; if (stallreq_o !== 1'b1 || inst_o !== 32'h0) begin
      bad++; $display("FAIL first_wait got stallreq=%b inst=%h required 1/0", stallreq_o, inst_o); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i), mem(32'(4 * i)));
      step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (ibus_addr_o !== 32'(4 * i) || stallreq_o !== 1'b0) begin
        bad++; $display("FAIL zw_addr got addr=%h stallreq=%b required addr=%h stallreq=0", ibus_addr_o, stallreq_o, 32'(4 * i)); end
    end
  endtask

  task automatic test_wait_ack();
    do_reset();
    run_seq(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (stallreq_o !== 1'b1 || ibus_addr_o !== 32'h8 || inst_o !== 32'h0) begin
        bad++; $display("FAIL wait_cycle got stallreq=%b addr=%h inst=%h required 1/8/0", stallreq_o, ibus_addr_o, inst_o); end
    end
    push(32'h8, mem(32'h8));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL wait_ackcyc stallreq got=%b required=0", stallreq_o); end
    push(32'hC, mem(32'hC));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'hC) begin bad++; $display("FAIL wait_next addr got=%h required=c", ibus_addr_o); end
  endtask

  task automatic test_branch();
    do_reset();
    run_seq(4);
    step(1'b0, 6'd0, 1'b1, 32'h100, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h10 || stallreq_o !== 1'b1) begin
      bad++; $display("FAIL br_slot addr got=%h stallreq=%b required 10/1", ibus_addr_o, stallreq_o); end
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h10) begin bad++; $display("FAIL br_slot_hold addr got=%h required=10", ibus_addr_o); end
    push(32'h10, mem(32'h10));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    // Branch in an advance cycle is taken directly.
    push(32'h100, mem(32'h100));
    step(1'b1, 6'd0, 1'b1, 32'h200, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h100) begin bad++; $display("FAIL br_pend_target addr got=%h required=100", ibus_addr_o); end
    push(32'h200, mem(32'h200));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h200) begin bad++; $display("FAIL br_direct addr got=%h required=200", ibus_addr_o); end
  endtask

  task automatic test_hold();
    do_reset();
    run_seq(8);
    push(32'h20, 32'h2402_0005);
    step(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, (i == 0) ? 6'b000011 : 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (ibus_req_o !== 1'b0 || pc_o !== 32'h20 || inst_o !== 32'h2402_0005 || stallreq_o !== 1'b0) begin
        bad++; $display("FAIL hold got req=%b pc=%h inst=%h stallreq=%b required 0/20/24020005/0", ibus_req_o, pc_o, inst_o, stallreq_o); end
    end
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h24) begin
      bad++; $display("FAIL hold_release got req=%b addr=%h required 1/24", ibus_req_o, ibus_addr_o); end
    push(32'h24, mem(32'h24));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_flush();
    do_reset();
    run_seq(16);
    step(1'b0, 6'd0, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h180);
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h40 || inst_o !== 32'h0 || stallreq_o !== 1'b1) begin
      bad++; $display("FAIL drain got req=%b addr=%h inst=%h stallreq=%b required 1/40/0/1", ibus_req_o, ibus_addr_o, inst_o, stallreq_o); end
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (inst_o !== 32'h0 || stallreq_o !== 1'b1) begin
      bad++; $display("FAIL drain_ack got inst=%h stallreq=%b required 0/1", inst_o, stallreq_o); end
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h180) begin bad++; $display("FAIL flush_target addr got=%h required=180", ibus_addr_o); end
    push(32'h180, mem(32'h180));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    push(32'h184, mem(32'h184));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h184) begin bad++; $display("FAIL flush_pend_clear addr got=%h required=184", ibus_addr_o); end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    rst = 1'b1; ibus_ack_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0; stall = 6'd0;
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b1; new_pc_i = 32'h500;
    push(32'h500, mem(32'h500));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h500) begin bad++; $display("FAIL flush_idle addr got=%h required=500", ibus_addr_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_seq(2);
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ibus_ack_i = 1'b1;
    #1;
    total++; if (ibus_req_o !== 1'b0 || inst_o !== 32'h0 || stallreq_o !== 1'b0) begin
      bad++; $display("FAIL late_ack got req=%b inst=%h stallreq=%b required 0/0/0", ibus_req_o, inst_o, stallreq_o); end
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      bad++; $display("FAIL rst_restart got req=%b addr=%h required 1/0", ibus_req_o, ibus_addr_o); end
  endtask

  task automatic test_misalign();
    do_reset();
    push(32'h0, mem(32'h0));
    step(1'b1, 6'd0, 1'b1, 32'h102, 1'b0, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b0 || addr_err_o !== 1'b1 || pc_o !== 32'h102 || inst_o !== 32'h0 || stallreq_o !== 1'b0) begin
      bad++; $display("FAIL misalign got req=%b err=%b pc=%h inst=%h stallreq=%b required 0/1/102/0/0", ibus_req_o, addr_err_o, pc_o, inst_o, stallreq_o); end
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (pc_o !== 32'h106 || addr_err_o !== 1'b1) begin
      bad++; $display("FAIL misalign_next got pc=%h err=%b required 106/1", pc_o, addr_err_o); end
`else
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100 || pc_o !== 32'h102 || addr_err_o !== 1'b0) begin
      bad++; $display("FAIL align_force got req=%b addr=%h pc=%h err=%b required 1/100/102/0", ibus_req_o, ibus_addr_o, pc_o, addr_err_o); end
    push(32'h102, mem(32'h100));
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (ibus_addr_o !== 32'h104 || pc_o !== 32'h106) begin
      bad++; $display("FAIL align_next got addr=%h pc=%h required 104/106", ibus_addr_o, pc_o); end
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush_i = 1'b0; new_pc_i = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0; ibus_ack_i = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_ack();
    test_branch();
    test_hold();
    test_flush();
    test_flush_idle();
    test_mid_reset();
    test_misalign();
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
